// File: rtl/n_lane_gearbox.sv
// N-to-one request gearbox: pops one NUM_LANES-wide word from an FWFT FIFO and
// serialises its valid lanes, one beat per cycle, tagged with sequence number and one-hot lane id.
module n_lane_gearbox #(
    parameter int unsigned NUM_LANES    = 4,
    parameter int unsigned INT_WIDTH    = 33,
    parameter int unsigned CNT_WIDTH    = 28,
    parameter int unsigned SKIP_INVALID = 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     input_empty,
    input  logic [NUM_LANES*INT_WIDTH-1:0]           input_lanes,
    output logic                                     input_rd_en,
    input  logic                                     output_full,
    output logic [CNT_WIDTH+NUM_LANES+INT_WIDTH-2:0] output_one,
    output logic                                     output_wr_en,
    output logic                                     busy
);

    localparam int unsigned DATA_W = INT_WIDTH - 1;
    localparam int unsigned OUT_W  = CNT_WIDTH + NUM_LANES + DATA_W;
    localparam int unsigned SEL_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam bit          SKIP   = (SKIP_INVALID != 0);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]                           state;
    logic [0:0]                           state_next;
    logic [NUM_LANES-1:0][DATA_W-1:0]     hold_data;
    logic [NUM_LANES-1:0][DATA_W-1:0]     hold_next;
    logic [NUM_LANES-1:0]                 pend_mask;
    logic [NUM_LANES-1:0]                 mask_next;
    logic [CNT_WIDTH-1:0]                 tag;
    logic [CNT_WIDTH-1:0]                 tag_next;
    logic [CNT_WIDTH-1:0]                 seq;
    logic [CNT_WIDTH-1:0]                 seq_next;
    logic [SEL_W-1:0]                     slot;
    logic [SEL_W-1:0]                     slot_next;
    logic [OUT_W-1:0]                     one_next;
    logic                                 wr_next;

    logic [NUM_LANES-1:0]                 in_mask;
    logic [NUM_LANES-1:0][DATA_W-1:0]     in_data;
    logic [SEL_W-1:0]                     first_set;
    logic                                 found;
    logic [SEL_W-1:0]                     sel;
    logic [NUM_LANES-1:0]                 sel_onehot;
    logic                                 sel_valid;
    logic                                 is_last;
    logic                                 issue;
    logic                                 last_issue;

    // Split the incoming word into per-lane valid bits and payloads; lane 0 sits at the MSBs.
    always_comb begin
        in_mask = '0;
        in_data = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            in_mask[i] = input_lanes[(NUM_LANES - i) * INT_WIDTH - 1];
            in_data[i] = input_lanes[(NUM_LANES - i) * INT_WIDTH - 2 -: DATA_W];
        end
    end

    // Lowest pending lane, used when invalid lanes are skipped.
    always_comb begin
        first_set = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (!found && pend_mask[i]) begin
                first_set = SEL_W'(i);
                found     = 1'b1;
            end
        end
    end

    assign sel        = SKIP ? first_set : slot;
    assign sel_onehot = NUM_LANES'(1) << sel;
    assign sel_valid  = pend_mask[sel];
    assign is_last    = SKIP ? ((pend_mask & (pend_mask - NUM_LANES'(1))) == '0)
                             : (slot == SEL_W'(NUM_LANES - 1));
    assign issue      = (state == ST_DRAIN) && !output_full;
    assign last_issue = issue && is_last;

    // Pop is allowed in the same cycle as the final issue so words stream back to back.
    assign input_rd_en = !rst && !input_empty && ((state == ST_IDLE) || last_issue);

    always_comb begin
        state_next = state;
        hold_next  = hold_data;
        mask_next  = pend_mask;
        tag_next   = tag;
        seq_next   = seq;
        slot_next  = slot;
        one_next   = output_one;
        wr_next    = 1'b0;

        if (issue) begin
            wr_next   = sel_valid;
            if (sel_valid) begin
                one_next = {tag, sel_onehot, hold_data[sel]};
            end
            mask_next = pend_mask & ~sel_onehot;
            slot_next = slot + SEL_W'(1);
            if (last_issue) begin
                state_next = ST_IDLE;
            end
        end

        // A fresh capture overrides the bookkeeping of the word that just finished.
        if (input_rd_en) begin
            hold_next  = in_data;
            mask_next  = in_mask;
            tag_next   = seq;
            seq_next   = seq + CNT_WIDTH'(1);
            slot_next  = '0;
            state_next = (SKIP && (in_mask == '0)) ? ST_IDLE : ST_DRAIN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            hold_data    <= '0;
            pend_mask    <= '0;
            tag          <= '0;
            seq          <= CNT_WIDTH'(1);
            slot         <= '0;
            output_one   <= '0;
            output_wr_en <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            hold_data    <= hold_next;
            pend_mask    <= mask_next;
            tag          <= tag_next;
            seq          <= seq_next;
            slot         <= slot_next;
            output_one   <= one_next;
            output_wr_en <= wr_next;
            busy         <= (state_next == ST_DRAIN);
        end
    end

endmodule

// File: tb/tb_n_lane_gearbox.sv
// Directed bench for n_lane_gearbox: skip mode, fixed-cadence mode and a narrow
// sequence counter instance, each fed from its own FWFT FIFO model.
module tb_n_lane_gearbox;

    typedef struct {
        logic       full;
        logic       rd;
        logic       wr;
        logic       chk;
        logic [3:0] oh;
        int         seq;
        int         word;
        int         lane;
        logic       busy;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   empty_v;
    logic [2:0]   full_v;
    wire  [2:0]   rd_v;
    wire  [2:0]   wr_v;
    wire  [2:0]   busy_v;
    logic [131:0] lanes0, lanes1, lanes2;
    wire  [63:0]  one0, one1;
    wire  [38:0]  one2;

    logic [131:0] q0[$];
    logic [131:0] q1[$];
    logic [131:0] q2[$];
    vec_t         tbl[$];

    int checks = 0;
    int errors = 0;
    string tname = "reset";

    always #5 clk = ~clk;

    n_lane_gearbox #(.NUM_LANES(4), .INT_WIDTH(33), .CNT_WIDTH(28), .SKIP_INVALID(1)) u_skip (
        .clk(clk), .rst(rst), .input_empty(empty_v[0]), .input_lanes(lanes0),
        .input_rd_en(rd_v[0]), .output_full(full_v[0]), .output_one(one0),
        .output_wr_en(wr_v[0]), .busy(busy_v[0]));

    n_lane_gearbox #(.NUM_LANES(4), .INT_WIDTH(33), .CNT_WIDTH(28), .SKIP_INVALID(0)) u_cad (
        .clk(clk), .rst(rst), .input_empty(empty_v[1]), .input_lanes(lanes1),
        .input_rd_en(rd_v[1]), .output_full(full_v[1]), .output_one(one1),
        .output_wr_en(wr_v[1]), .busy(busy_v[1]));

    n_lane_gearbox #(.NUM_LANES(4), .INT_WIDTH(33), .CNT_WIDTH(3), .SKIP_INVALID(1)) u_wrap (
        .clk(clk), .rst(rst), .input_empty(empty_v[2]), .input_lanes(lanes2),
        .input_rd_en(rd_v[2]), .output_full(full_v[2]), .output_one(one2),
        .output_wr_en(wr_v[2]), .busy(busy_v[2]));

    function automatic logic [31:0] lane_val(input int w, input int l);
        return 32'hA500_0000 | (32'(w) << 8) | 32'(l);
    endfunction

    function automatic logic [131:0] make_word(input int w, input logic [3:0] mask);
        logic [131:0] r;
        r = '0;
        for (int l = 0; l < 4; l++) begin
            r[(4 - l) * 33 - 1 -: 33] = {mask[l], lane_val(w, l)};
        end
        return r;
    endfunction

    function automatic logic [63:0] exp_one(input int d, input int s, input logic [3:0] oh,
                                            input int w, input int l);
        if (d == 2) return 64'({3'(s), oh, lane_val(w, l)});
        return {28'(s), oh, lane_val(w, l)};
    endfunction

    function automatic vec_t mk(input logic full, input logic rd, input logic wr, input logic chk,
                                input logic [3:0] oh, input int s, input int w, input int l,
                                input logic b);
        vec_t v;
        v.full = full; v.rd = rd; v.wr = wr; v.chk = chk; v.oh = oh;
        v.seq = s; v.word = w; v.lane = l; v.busy = b;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s at %0t: got %h expected %h", tname, name, $time, act, exp);
        end
    endtask

    task automatic refresh();
        empty_v[0] = (q0.size() == 0);
        lanes0 = '0;
        if (q0.size() != 0) lanes0 = q0[0];
        empty_v[1] = (q1.size() == 0);
        lanes1 = '0;
        if (q1.size() != 0) lanes1 = q1[0];
        empty_v[2] = (q2.size() == 0);
        lanes2 = '0;
        if (q2.size() != 0) lanes2 = q2[0];
    endtask

    // One clock of stimulus and checks for instance d; entered and left at posedge+1.
    task automatic step(input int d, input vec_t v);
        logic [2:0]  pop;
        logic [63:0] act_one;
        full_v    = '0;
        full_v[d] = v.full;
        #1;
        check("rd_en", 64'(rd_v[d]), 64'(v.rd));
        pop = rd_v;
        @(posedge clk);
        #1;
        if (pop[0]) void'(q0.pop_front());
        if (pop[1]) void'(q1.pop_front());
        if (pop[2]) void'(q2.pop_front());
        refresh();
        check("wr_en", 64'(wr_v[d]), 64'(v.wr));
        check("busy", 64'(busy_v[d]), 64'(v.busy));
        if (v.chk) begin
            act_one = (d == 0) ? one0 : (d == 1) ? one1 : 64'(one2);
            check("output_one", act_one, exp_one(d, v.seq, v.oh, v.word, v.lane));
        end
    endtask

    task automatic run_tbl(input int d);
        for (int i = 0; i < tbl.size(); i++) begin
            step(d, tbl[i]);
        end
        tbl.delete();
    endtask

    initial begin
        rst    = 1'b1;
        full_v = '0;
        q0.push_back(make_word(1, 4'b1111));
        refresh();
        repeat (2) @(posedge clk);
        #1;
        check("rd_en_in_reset", 64'(rd_v), 64'(0));
        check("wr_en_reset", 64'(wr_v), 64'(0));
        check("busy_reset", 64'(busy_v), 64'(0));
        check("one0_reset", one0, 64'(0));
        check("one1_reset", one1, 64'(0));
        check("one2_reset", 64'(one2), 64'(0));
        rst = 1'b0;

        tname = "all_valid";
        tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 4'b0001, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 4'b0010, 1, 1, 1, 1));
        tbl.push_back(mk(0, 0, 1, 1, 4'b0100, 1, 1, 2, 1));
        tbl.push_back(mk(0, 0, 1, 1, 4'b1000, 1, 1, 3, 0));
        tbl.push_back(mk(0, 0, 0, 1, 4'b1000, 1, 1, 3, 0));
        run_tbl(0);

        tname = "skip_mask_1010";
        q0.push_back(make_word(2, 4'b1010));
        refresh();
        tbl.push_back(mk(0, 1, 0, 1, 4'b1000, 1, 1, 3, 1));
        tbl.push_back(mk(0, 0, 1, 1, 4'b0010, 2, 2, 1, 1));
        tbl.push_back(mk(0, 0, 1, 1, 4'b1000, 2, 2, 3, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
        run_tbl(0);

        tname = "cadence_mask_1010";
        q1.push_back(make_word(2, 4'b1010));
        refresh();
        tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 4'b0010, 1, 2, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 4'b0010, 1, 2, 1, 1));
        tbl.push_back(mk(0, 0, 1, 1, 4'b1000, 1, 2, 3, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
        run_tbl(1);

        tname = "back_to_back";
        q0.push_back(make_word(3, 4'b1111));
        q0.push_back(make_word(4, 4'b1111));
        refresh();
        tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 4'b0001, 3, 3, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 4'b0010, 3, 3, 1, 1));
        tbl.push_back(mk(0, 0, 1, 1, 4'b0100, 3, 3, 2, 1));
        tbl.push_back(mk(0, 1, 1, 1, 4'b1000, 3, 3, 3, 1));
        tbl.push_back(mk(0, 0, 1, 1, 4'b0001, 4, 4, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 4'b0010, 4, 4, 1, 1));
        tbl.push_back(mk(0, 0, 1, 1, 4'b0100, 4, 4, 2, 1));
        tbl.push_back(mk(0, 0, 1, 1, 4'b1000, 4, 4, 3, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
        run_tbl(0);

        tname = "backpressure";
        q0.push_back(make_word(5, 4'b1111));
        q0.push_back(make_word(6, 4'b0001));
        refresh();
        tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 4'b0001, 5, 5, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 4'b0010, 5, 5, 1, 1));
        tbl.push_back(mk(1, 0, 0, 1, 4'b0010, 5, 5, 1, 1));
        tbl.push_back(mk(1, 0, 0, 1, 4'b0010, 5, 5, 1, 1));
        tbl.push_back(mk(1, 0, 0, 1, 4'b0010, 5, 5, 1, 1));
        tbl.push_back(mk(0, 0, 1, 1, 4'b0100, 5, 5, 2, 1));
        tbl.push_back(mk(1, 0, 0, 1, 4'b0100, 5, 5, 2, 1));
        tbl.push_back(mk(0, 1, 1, 1, 4'b1000, 5, 5, 3, 1));
        tbl.push_back(mk(0, 0, 1, 1, 4'b0001, 6, 6, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 4'b0001, 6, 6, 0, 0));
        run_tbl(0);

        tname = "invalid_word";
        q0.push_back(make_word(7, 4'b0000));
        q0.push_back(make_word(8, 4'b0101));
        refresh();
        tbl.push_back(mk(0, 1, 0, 1, 4'b0001, 6, 6, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 4'b0001, 8, 8, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 4'b0100, 8, 8, 2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
        run_tbl(0);

        tname = "reset_mid_drain";
        q0.push_back(make_word(9, 4'b1111));
        refresh();
        tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 4'b0001, 9, 9, 0, 1));
        run_tbl(0);
        q0.push_back(make_word(10, 4'b1111));
        refresh();
        rst = 1'b1;
        #1;
        check("rd_en_in_reset", 64'(rd_v), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("wr_en_after_rst", 64'(wr_v), 64'(0));
        check("busy_after_rst", 64'(busy_v), 64'(0));
        check("one0_after_rst", one0, 64'(0));
        tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 4'b0001, 1, 10, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 4'b0010, 1, 10, 1, 1));
        tbl.push_back(mk(0, 0, 1, 1, 4'b0100, 1, 10, 2, 1));
        tbl.push_back(mk(0, 0, 1, 1, 4'b1000, 1, 10, 3, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
        run_tbl(0);

        tname = "seq_wrap";
        for (int k = 0; k < 9; k++) begin
            q2.push_back(make_word(20 + k, 4'b0001));
        end
        refresh();
        tbl.push_back(mk(0, 1, 0, 0, 4'b0000, 0, 0, 0, 1));
        for (int k = 0; k < 9; k++) begin
            tbl.push_back(mk(0, k < 8, 1, 1, 4'b0001, (k + 1) % 8, 20 + k, 0, k < 8));
        end
        tbl.push_back(mk(0, 0, 0, 1, 4'b0001, 1, 28, 0, 0));
        run_tbl(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
